// File: rtl/segre_ic_refill.sv
// segre_ic_refill
// Instruction-cache refill unit sitting upstream of the IF stage. On an
// I-cache miss it fetches the enclosing lane from memory one word-beat at a
// time (one outstanding transaction), then presents the full lane with a
// one-cycle write strobe. It also keeps true-LRU ages for the I-cache lanes,
// updated by IF hits and by completed fills, and supplies the victim index.
//
// Ports:
//   clk_i, rsn_i        clock, synchronous active-low reset
//   ic_access_i         IF performed a tag lookup this cycle
//   ic_miss_i           the lookup missed
//   ic_addr_i           miss: faulting PC; hit: lane index in low bits
//   mmu_data_o          one-cycle strobe, lane data and index valid
//   mmu_wr_data_o       refilled lane (beat 0 in the low word)
//   mmu_lru_index_o     victim lane index
//   mem_req_o           memory read request
//   mem_addr_o          byte address of the requested beat
//   mem_gnt_i           request accepted this cycle
//   mem_rvalid_i        read data valid
//   mem_rdata_i         read data
//   busy_o              a refill is in progress
module segre_ic_refill #(
   parameter int ADDR_SIZE         = 32,
   parameter int WORD_SIZE         = 32,
   parameter int ICACHE_LANE_SIZE  = 128,
   parameter int ICACHE_LINES      = 4,
   parameter int ICACHE_INDEX_SIZE = 2
) (
   input  logic                         clk_i,
   input  logic                         rsn_i,
   input  logic                         ic_access_i,
   input  logic                         ic_miss_i,
   input  logic [ADDR_SIZE-1:0]         ic_addr_i,
   output logic                         mmu_data_o,
   output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
   output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
   output logic                         mem_req_o,
   output logic [ADDR_SIZE-1:0]         mem_addr_o,
   input  logic                         mem_gnt_i,
   input  logic                         mem_rvalid_i,
   input  logic [WORD_SIZE-1:0]         mem_rdata_i,
   output logic                         busy_o
);

   localparam int BEATS      = ICACHE_LANE_SIZE / WORD_SIZE;
   localparam int LANE_BYTES = ICACHE_LANE_SIZE / 8;
   localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [ADDR_SIZE-1:0]         OFF_MASK   = ADDR_SIZE'(LANE_BYTES - 1);
   localparam logic [ADDR_SIZE-1:0]         BEAT_BYTES = ADDR_SIZE'(WORD_SIZE / 8);
   localparam logic [BW-1:0]                LAST_BEAT  = BW'(BEATS - 1);
   localparam logic [ICACHE_INDEX_SIZE-1:0] OLDEST     = ICACHE_INDEX_SIZE'(ICACHE_LINES - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                                            state, state_n;
   logic [ADDR_SIZE-1:0]                              base;
   logic [BW-1:0]                                     beat;
   logic [ICACHE_LANE_SIZE-1:0]                       lane;
   logic [ICACHE_LINES-1:0][ICACHE_INDEX_SIZE-1:0]    age, age_n;
   logic [ICACHE_INDEX_SIZE-1:0]                      victim_q, victim_n;
   logic                                              touch;
   logic [ICACHE_INDEX_SIZE-1:0]                      touch_idx;

   // ---------------- refill FSM ----------------
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (ic_miss_i) state_n = REQ;
         REQ:  if (mem_gnt_i) state_n = WAIT;
         WAIT: if (mem_rvalid_i) state_n = (beat == LAST_BEAT) ? DONE : REQ;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state <= IDLE;
         base  <= '0;
         beat  <= '0;
         lane  <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && ic_miss_i) begin
            base <= ic_addr_i & ~OFF_MASK;
            beat <= '0;
         end
         if (state == WAIT && mem_rvalid_i) begin
            lane[beat*WORD_SIZE +: WORD_SIZE] <= mem_rdata_i;
            // Counter parks on the last beat; it is cleared on the next miss.
            if (beat != LAST_BEAT) beat <= beat + 1'b1;
         end
      end
   end

   // ---------------- true-LRU ages ----------------
   // A miss in IDLE suppresses the hit touch; a fill touches its own
   // (frozen) victim in DONE.
   always_comb begin
      touch     = (state == IDLE && ic_access_i && !ic_miss_i) || (state == DONE);
      touch_idx = (state == DONE) ? victim_q : ic_addr_i[ICACHE_INDEX_SIZE-1:0];
      age_n     = age;
      if (touch) begin
         for (int i = 0; i < ICACHE_LINES; i++)
            if (age[i] < age[touch_idx]) age_n[i] = age[i] + 1'b1;
         age_n[touch_idx] = '0;
      end
   end

   // Victim is looked up on the post-update ages so the index register
   // tracks the ages with no extra lag.
   always_comb begin
      victim_n = '0;
      for (int i = 0; i < ICACHE_LINES; i++)
         if (age_n[i] == OLDEST) victim_n = ICACHE_INDEX_SIZE'(i);
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         for (int i = 0; i < ICACHE_LINES; i++)
            age[i] <= ICACHE_INDEX_SIZE'(ICACHE_LINES - 1 - i);
         victim_q <= '0;
      end else begin
         age <= age_n;
         // Held through REQ/WAIT so the fill writes the lane chosen at miss time.
         if (state == IDLE || state == DONE) victim_q <= victim_n;
      end
   end

   // ---------------- outputs ----------------
   assign mem_req_o       = (state == REQ);
   assign mem_addr_o      = (state == REQ) ? base + (ADDR_SIZE'(beat) * BEAT_BYTES) : '0;
   assign mmu_data_o      = (state == DONE);
   assign mmu_wr_data_o   = lane;
   assign mmu_lru_index_o = victim_q;
   assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_segre_ic_refill.sv
// Self-checking bench for segre_ic_refill. A cycle-driven memory responder
// with programmable grant/rvalid delay feeds the DUT; expected lanes,
// addresses, strobe cycle and LRU victim come from a recency-queue model.
module tb_segre_ic_refill;

   localparam int L     = 4;
   localparam int BEATS = 4;

   logic         clk = 1'b0;
   logic         rsn;
   logic         ic_access, ic_miss;
   logic [31:0]  ic_addr;
   logic         mmu_data;
   logic [127:0] mmu_wr_data;
   logic [1:0]   mmu_lru_index;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_gnt, mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         busy;

   int n_chk = 0;
   int n_fail = 0;
   int lru_q[$];   // lane numbers, most recently used first

   always #5 clk = ~clk;

   segre_ic_refill dut (
      .clk_i(clk), .rsn_i(rsn),
      .ic_access_i(ic_access), .ic_miss_i(ic_miss), .ic_addr_i(ic_addr),
      .mmu_data_o(mmu_data), .mmu_wr_data_o(mmu_wr_data), .mmu_lru_index_o(mmu_lru_index),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   // ---------------- reference LRU model ----------------
   function automatic void m_reset();
      lru_q.delete();
      for (int i = L - 1; i >= 0; i--) lru_q.push_back(i);
   endfunction

   function automatic void m_touch(int k);
      for (int i = 0; i < lru_q.size(); i++)
         if (lru_q[i] == k) begin
            lru_q.delete(i);
            break;
         end
      lru_q.push_front(k);
   endfunction

   function automatic int m_victim();
      return lru_q[$];
   endfunction

   task automatic idle_inputs();
      ic_access = 0; ic_miss = 0; ic_addr = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   // One refill from miss to strobe. Entered and left just after a negedge.
   task automatic do_fill(input logic [31:0] addr, input int gd, input int rd,
                          input logic [127:0] words, input bit noise,
                          output int strobe_cyc, output logic [1:0] got_idx);
      logic [31:0] base;
      int b, rc, wc, exp_cyc, ev;
      bit waiting, done;
      base = addr & ~32'hF;
      b = 0; rc = 0; wc = 0; waiting = 0; done = 0;
      exp_cyc = 1 + BEATS * (2 + gd + rd);
      ev = m_victim();
      strobe_cyc = -1; got_idx = '0;
      ic_miss = 1; ic_addr = addr; ic_access = 1'($urandom_range(0, 1));
      mem_gnt = 0; mem_rvalid = 0;
      for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
         @(negedge clk);
         ic_miss = 0; ic_access = 0; mem_gnt = 0; mem_rvalid = 0;
         n_chk++;
         if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_during_fill: cycle %0d got %b want 1", cyc, busy);
         end
         if (mmu_data === 1'b1) begin
            strobe_cyc = cyc; got_idx = mmu_lru_index; done = 1;
            n_chk++;
            if (cyc != exp_cyc) begin
               n_fail++; $display("FAIL strobe_cycle: got %0d want %0d", cyc, exp_cyc);
            end
            n_chk++;
            if (mmu_wr_data !== words) begin
               n_fail++; $display("FAIL lane_data: got %h want %h", mmu_wr_data, words);
            end
            n_chk++;
            if (mmu_lru_index !== 2'(ev)) begin
               n_fail++; $display("FAIL fill_victim: got %0d want %0d", mmu_lru_index, ev);
            end
            m_touch(ev);
         end else if (!waiting) begin
            n_chk++;
            if (mem_req !== 1'b1 || mem_addr !== base + 32'(4 * b)) begin
               n_fail++;
               $display("FAIL req_addr: cycle %0d got req=%b addr=%h want req=1 addr=%h",
                        cyc, mem_req, mem_addr, base + 32'(4 * b));
            end
            if (rc == gd) begin
               mem_gnt = 1; waiting = 1; wc = 0;
            end
            rc++;
         end else begin
            n_chk++;
            if (mem_req !== 1'b0) begin
               n_fail++; $display("FAIL req_in_wait: cycle %0d got %b want 0", cyc, mem_req);
            end
            if (wc == rd) begin
               mem_rvalid = 1; mem_rdata = words[b*32 +: 32]; b++; waiting = 0; rc = 0;
            end
            wc++;
         end
         if (noise && !done) begin
            ic_miss = 1'($urandom_range(0, 1));
            ic_access = 1'($urandom_range(0, 1));
            ic_addr = $urandom;
         end
      end
      n_chk++;
      if (!done) begin
         n_fail++; $display("FAIL fill_timeout: no strobe within 300 cycles, want 1 strobe");
         idle_inputs();
      end else begin
         @(negedge clk);
         n_chk++;
         if (busy !== 1'b0 || mmu_data !== 1'b0) begin
            n_fail++; $display("FAIL after_done: got busy=%b strobe=%b want 0 0", busy, mmu_data);
         end
         n_chk++;
         if (mmu_lru_index !== 2'(m_victim())) begin
            n_fail++; $display("FAIL post_fill_victim: got %0d want %0d", mmu_lru_index, m_victim());
         end
         @(negedge clk);
         n_chk++;
         if (mem_req !== 1'b0 || mmu_data !== 1'b0 || mmu_wr_data !== words) begin
            n_fail++;
            $display("FAIL idle_hold: got req=%b strobe=%b lane=%h want 0 0 %h",
                     mem_req, mmu_data, mmu_wr_data, words);
         end
      end
   endtask

   task automatic hit(input int k);
      ic_access = 1; ic_miss = 0; ic_addr = ($urandom & ~32'h3) | 32'(k);
      m_touch(k);
      @(negedge clk);
      ic_access = 0;
      @(negedge clk);
      n_chk++;
      if (mmu_lru_index !== 2'(m_victim())) begin
         n_fail++; $display("FAIL hit_victim: got %0d want %0d", mmu_lru_index, m_victim());
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      n_chk++;
      if (mmu_data !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
          mmu_wr_data !== 128'h0 || mmu_lru_index !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got strobe=%b req=%b addr=%h lane=%h idx=%0d busy=%b want all 0",
                  tag, mmu_data, mem_req, mem_addr, mmu_wr_data, mmu_lru_index, busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rsn = 0;
      for (int c = 0; c < 2; c++) begin
         ic_access = 1'($urandom_range(0, 1)); ic_miss = 1'($urandom_range(0, 1));
         ic_addr = $urandom; mem_gnt = 1'($urandom_range(0, 1));
         mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         @(negedge clk);
         check_zero_outputs("reset_outputs");
      end
      rsn = 1;
      idle_inputs();
      m_reset();
      @(negedge clk);
   endtask

   task automatic test_basic();
      int sc;
      logic [1:0] idx;
      do_fill(32'h0000_1234, 0, 0, 128'h44444444_33333333_22222222_11111111, 0, sc, idx);
      n_chk++;
      if (sc != 9 || idx !== 2'd0) begin
         n_fail++; $display("FAIL basic_fill: got cycle %0d idx %0d want 9 0", sc, idx);
      end
   endtask

   task automatic test_backpressure();
      int sc;
      logic [1:0] idx;
      do_fill(32'h0000_1234, 3, 2, 128'h44444444_33333333_22222222_11111111, 0, sc, idx);
      n_chk++;
      if (sc != 29) begin
         n_fail++; $display("FAIL backpressure_cycle: got %0d want 29", sc);
      end
   endtask

   task automatic test_lru();
      int sc;
      logic [1:0] idx;
      test_reset();
      for (int i = 0; i < L; i++) begin
         do_fill($urandom, 0, 0, {$urandom, $urandom, $urandom, $urandom}, 0, sc, idx);
         n_chk++;
         if (idx !== 2'(i)) begin
            n_fail++; $display("FAIL lru_order: fill %0d got %0d want %0d", i, idx, i);
         end
      end
      hit(0);
      do_fill($urandom, 0, 0, {$urandom, $urandom, $urandom, $urandom}, 0, sc, idx);
      n_chk++;
      if (idx !== 2'd1) begin
         n_fail++; $display("FAIL lru_after_hit: got %0d want 1", idx);
      end
   endtask

   task automatic test_reset_mid();
      int sc;
      logic [1:0] idx;
      ic_miss = 1; ic_addr = $urandom;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         idle_inputs();
         if (c % 2 == 1) mem_gnt = 1;
         else begin
            mem_rvalid = 1; mem_rdata = $urandom;
         end
      end
      @(negedge clk);
      idle_inputs();
      rsn = 0;
      @(negedge clk);
      check_zero_outputs("mid_reset_outputs");
      rsn = 1; mem_rvalid = 1; mem_rdata = $urandom;
      m_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle_inputs();
         check_zero_outputs("stray_beat_ignored");
      end
      do_fill(32'h0000_ABC8, 0, 0, {$urandom, $urandom, $urandom, $urandom}, 0, sc, idx);
   endtask

   task automatic test_random();
      int sc;
      logic [1:0] idx;
      for (int it = 0; it < 20; it++) begin
         int nh = $urandom_range(0, 3);
         for (int h = 0; h < nh; h++) hit($urandom_range(0, L - 1));
         do_fill($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 {$urandom, $urandom, $urandom, $urandom}, 1, sc, idx);
      end
   endtask

   initial begin
      rsn = 0;
      idle_inputs();
      m_reset();
      test_reset();
      test_basic();
      test_backpressure();
      test_lru();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
